// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Per-channel 2-flop synchronizer plus counter filter, with optional
//            rise/fall pulses (define INPUT_DEBOUNCER_EDGE_DETECT_EN).
// Revision : 1.0
// ============================================================================
module input_debouncer #(
  parameter int                    NUM_INPUTS      = 2,
  parameter int                    DEBOUNCE_CYCLES = 120000,
  parameter logic [NUM_INPUTS-1:0] RESET_VALUE     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_input,
  output logic [NUM_INPUTS-1:0] debounced,
  output logic [NUM_INPUTS-1:0] rise,
  output logic [NUM_INPUTS-1:0] fall
);

  localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_term_cnt = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  logic [NUM_INPUTS-1:0] sync1_q;
  logic [NUM_INPUTS-1:0] sync2_q;
  logic [NUM_INPUTS-1:0] deb_q;
  logic [NUM_INPUTS-1:0] deb_d;
  logic [c_cnt_w-1:0]    cnt_q [NUM_INPUTS];
  logic [c_cnt_w-1:0]    cnt_d [NUM_INPUTS];
  state_e                w_state [NUM_INPUTS];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      deb_q   <= RESET_VALUE;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_input;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The state is implied by the sync2/debounced mismatch, so a glitch that
  // ends before terminal count drops straight back to STABLE with count 0.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_state[i] = (sync2_q[i] != deb_q[i]) ? COUNTING : STABLE;
      cnt_d[i]   = '0;
      case (w_state[i])
        COUNTING: begin
          if (cnt_q[i] == c_term_cnt) begin
            deb_d[i] = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  assign debounced = deb_q;

`ifdef INPUT_DEBOUNCER_EDGE_DETECT_EN
  logic [NUM_INPUTS-1:0] rise_q;
  logic [NUM_INPUTS-1:0] fall_q;

  // Registered alongside deb_q so the pulse coincides with the new level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= deb_d & ~deb_q;
      fall_q <= ~deb_d & deb_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer (D=4 and D=1).
// Revision : 1.0
// ============================================================================
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst4, rst1;
  logic [1:0] raw4, raw1;
  logic [1:0] deb4, rise4, fall4;
  logic [1:0] deb1, rise1, fall1;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  input_debouncer #(.NUM_INPUTS(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(2'b00)) dut4 (
    .clock(clk), .reset(rst4), .raw_input(raw4),
    .debounced(deb4), .rise(rise4), .fall(fall4)
  );

  input_debouncer #(.NUM_INPUTS(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(2'b11)) dut1 (
    .clock(clk), .reset(rst1), .raw_input(raw1),
    .debounced(deb1), .rise(rise1), .fall(fall1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst1 = 1'b1; raw4 = 2'b00; raw1 = 2'b11;
    tick(); tick();
    checks++; if (deb4 !== 2'b00) begin failures++; $display("FAIL reset_deb4 got %b expected 00", deb4); end
    checks++; if ({rise4, fall4} !== 4'b0) begin failures++; $display("FAIL reset_edges4 got %b expected 0000", {rise4, fall4}); end
    checks++; if (deb1 !== 2'b11) begin failures++; $display("FAIL reset_deb1 got %b expected 11", deb1); end
    checks++; if ({rise1, fall1} !== 4'b0) begin failures++; $display("FAIL reset_edges1 got %b expected 0000", {rise1, fall1}); end
    checks++; if (dut4.cnt_q[0] !== 3'd0) begin failures++; $display("FAIL reset_cnt got %0d expected 0", dut4.cnt_q[0]); end
    rst4 = 1'b0; rst1 = 1'b0;
    tick();
    checks++; if (deb1 !== 2'b11 || {rise1, fall1} !== 4'b0) begin failures++; $display("FAIL release1 got deb=%b edges=%b expected 11/0000", deb1, {rise1, fall1}); end
    checks++; if (deb4 !== 2'b00 || {rise4, fall4} !== 4'b0) begin failures++; $display("FAIL release4 got deb=%b edges=%b expected 00/0000", deb4, {rise4, fall4}); end
  endtask

  task automatic test_glitch();
    raw4 = 2'b01;
    tick(); tick(); tick();
    raw4 = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (deb4 !== 2'b00 || rise4 !== 2'b00) begin failures++; $display("FAIL glitch k=%0d got deb=%b rise=%b expected 00/00", k, deb4, rise4); end
    end
    checks++; if (dut4.cnt_q[0] !== 3'd0) begin failures++; $display("FAIL glitch_cnt got %0d expected 0", dut4.cnt_q[0]); end
  endtask

  // Apply target on dut4 and walk 8 edges; new level and pulse land on edge 6.
  task automatic run4(input string name, input logic [1:0] target, input logic [1:0] prev);
    logic [1:0] exp_deb, exp_rise, exp_fall;
    raw4 = target;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_deb  = (k >= 6) ? target : prev;
      exp_rise = (EDGE_EN && k == 6) ? (target & ~prev) : 2'b00;
      exp_fall = (EDGE_EN && k == 6) ? (~target & prev) : 2'b00;
      checks++; if (deb4 !== exp_deb) begin failures++; $display("FAIL %s_deb k=%0d got %b expected %b", name, k, deb4, exp_deb); end
      checks++; if (rise4 !== exp_rise || fall4 !== exp_fall) begin failures++; $display("FAIL %s_edges k=%0d got rise=%b fall=%b expected %b/%b", name, k, rise4, fall4, exp_rise, exp_fall); end
    end
  endtask

  task automatic test_rise_single();
    run4("rise0", 2'b01, 2'b00);
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int         rises;
    pat   = 6'b101101;
    rises = 0;
    for (int j = 0; j < 5; j++) begin
      raw4[1] = pat[5-j];
      tick();
      if (rise4[1]) rises++;
      checks++; if (deb4 !== 2'b01) begin failures++; $display("FAIL bounce_hold j=%0d got %b expected 01", j, deb4); end
    end
    raw4[1] = pat[0];
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (rise4[1]) rises++;
      checks++; if (deb4 !== ((k >= 6) ? 2'b11 : 2'b01)) begin failures++; $display("FAIL bounce_deb k=%0d got %b expected %b", k, deb4, (k >= 6) ? 2'b11 : 2'b01); end
    end
    checks++; if (rises !== (EDGE_EN ? 1 : 0)) begin failures++; $display("FAIL bounce_rises got %0d expected %0d", rises, EDGE_EN ? 1 : 0); end
  endtask

  task automatic test_fall_both();
    run4("fall_both", 2'b00, 2'b11);
  endtask

  task automatic test_simultaneous();
    run4("simul", 2'b11, 2'b00);
  endtask

  task automatic test_reset_midcount();
    rst4 = 1'b1; raw4 = 2'b00;
    tick(); tick();
    rst4 = 1'b0;
    raw4 = 2'b01;
    tick(); tick(); tick(); tick();
    checks++; if (dut4.cnt_q[0] !== 3'd2) begin failures++; $display("FAIL midcount_cnt got %0d expected 2", dut4.cnt_q[0]); end
    rst4 = 1'b1;
    tick();
    checks++; if (deb4 !== 2'b00 || {rise4, fall4} !== 4'b0) begin failures++; $display("FAIL midcount_reset got deb=%b edges=%b expected 00/0000", deb4, {rise4, fall4}); end
    checks++; if (dut4.cnt_q[0] !== 3'd0) begin failures++; $display("FAIL midcount_cnt_clr got %0d expected 0", dut4.cnt_q[0]); end
    rst4 = 1'b0;
    run4("after_reset", 2'b01, 2'b00);
  endtask

  task automatic test_fast();
    logic [3:0] seq;
    logic       prev, v;
    logic [1:0] exp_deb;
    seq  = 4'b0101;
    prev = 1'b1;
    for (int t = 0; t < 4; t++) begin
      v       = seq[3-t];
      raw1[0] = v;
      for (int k = 1; k <= 4; k++) begin
        tick();
        exp_deb = {1'b1, (k >= 3) ? v : prev};
        checks++; if (deb1 !== exp_deb) begin failures++; $display("FAIL fast_deb t=%0d k=%0d got %b expected %b", t, k, deb1, exp_deb); end
        checks++; if (rise1 !== {1'b0, EDGE_EN && k == 3 && v} || fall1 !== {1'b0, EDGE_EN && k == 3 && !v}) begin
          failures++; $display("FAIL fast_edges t=%0d k=%0d got rise=%b fall=%b", t, k, rise1, fall1);
        end
      end
      prev = v;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise_single();
    test_bounce();
    test_fall_both();
    test_simultaneous();
    test_reset_midcount();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
